bk_subtractor_pipe: RTL and testbench
=====================================

// Module: bk_subtractor_pipe
// PURPOSE
//  Pipelined 64-bit two's-complement subtractor: DIFF = A - B, computed as A + ~B + 1 on a Brent-Kung
//  parallel-prefix carry network split across 3 register stages.
//  Complements the combinational Brent-Kung adder in the datapath: it is the subtract/compare end of the
//  same arithmetic unit. Valid/ready streaming on both sides, with an opaque tag carried alongside each operation.
// PARAMETERS
//  WIDTH   64  operand/result width; must be a power of 2, 8..64
//  TAG_W   4   width of the pass-through tag; must be >= 1
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        A/B/in_tag are valid this cycle
//  in_ready   out  1        block accepts the operands this cycle
//  A          in   WIDTH    minuend
//  B          in   WIDTH    subtrahend
//  in_tag     in   TAG_W    opaque tag, returned with the result
//  out_valid  out  1        DIFF/flags/out_tag are valid
//  out_ready  in   1        consumer accepts the result this cycle
//  DIFF       out  WIDTH    A - B, modulo 2^WIDTH
//  borrow     out  1        1 when unsigned A < B (inverted final carry)
//  ovf        out  1        signed overflow: A[MSB]!=B[MSB] && DIFF[MSB]!=A[MSB]
//  out_tag    out  TAG_W    in_tag of this result
// BEHAVIOUR
//  - Reset (async assert, sync release): every stage valid bit = 0; out_valid=0; DIFF, borrow, ovf, out_tag = 0.
//    Operations in flight at reset are discarded; no output is produced for them.
//  - Stage S1 registers the accepted operands and generate/propagate terms:
//    Bn=~B, G=A&Bn, P=A^Bn; carry-in = 1.
//  - Stage S2 registers the Brent-Kung up-sweep group G/P for levels 1..log2(WIDTH)/2.
//  - Stage S3 finishes the up-sweep and down-sweep, forms all carries, and registers DIFF=P^C, borrow, ovf and tag.
//  - Latency: an operation accepted in cycle N has out_valid=1 in cycle N+3 if it does not stall.
//    Throughput: 1 operation per clock.
//  - Prefix cell: (g,p)o(g',p') = (g | p&g', p&p').
//    The carry into each bit is the full prefix including carry-in; no ripple chain is allowed.
//  - Handshake: an operation is transferred when valid && ready are both high on a clock edge.
//    - Stage k loads when stage k is empty or stage k's contents move on in the same cycle.
//    - in_ready = ~v1 | advance1. Bubbles collapse: a stall only backs up through stages that are full.
//    - in_ready must not depend combinationally on in_valid.
//  - While out_valid=1 and out_ready=0: DIFF, borrow, ovf and out_tag are held stable; out_valid is never dropped.
//  - Full pipe with out_ready=0: in_ready=0. The cycle out_ready rises, all stages shift and in_ready=1 (same cycle).
//  - Accepting a new input and emitting an output in the same cycle is legal and loses no data.
//  - Wrap-around is modular: 0 - 1 gives all ones with borrow=1; A==B gives 0 with borrow=0.
// CONFIGURATION
//  BK_SUB_FLAGS_EN defined:
//    - Adds output ports zero (DIFF==0) and neg (DIFF[MSB]). Both are registered in S3.
//    - Both reset to 0 and are held under stall exactly like DIFF.
//  BK_SUB_FLAGS_EN undefined: the zero and neg ports do not exist; all other behaviour is identical.
// TESTING
//  1 Reset: hold rst_n=0, then release -> out_valid=0, in_ready=1, DIFF=0. Assert rst_n mid-stream
//    -> out_valid drops immediately and no stale result appears afterwards.
//  2 Single op: A=5, B=3, tag=2 -> 3 cycles later DIFF=2, borrow=0, ovf=0, out_tag=2
//    (zero=0, neg=0 when BK_SUB_FLAGS_EN is defined).
//  3 Wrap: A=0, B=1 -> DIFF=64'hFFFF_FFFF_FFFF_FFFF, borrow=1, ovf=0 (neg=1).
//    A=B=64'h1234 -> DIFF=0, borrow=0 (zero=1).
//  4 Overflow: A=64'h8000_0000_0000_0000, B=1 -> DIFF=64'h7FFF_FFFF_FFFF_FFFF, ovf=1, borrow=0.
//    A=64'h7FFF_FFFF_FFFF_FFFF, B=-1 -> ovf=1, borrow=1.
//  5 Backpressure: stream 8 ops with out_ready=0 -> exactly 3 accepted, then in_ready=0, outputs stable.
//    Raise out_ready -> all 8 results delivered in order, tags 0..7, one per cycle.
//  6 Random: 10k random A/B/tags with random in_valid/out_ready -> every result matches the model A-B
//    (mod 2^64) with correct borrow/ovf; order preserved; no loss or duplication.

Source files
------------

// File: rtl/bk_subtractor_pipe_if.sv
// Valid/ready operand and result streams of the pipelined Brent-Kung subtractor.
// The zero/neg result flags exist only when BK_SUB_FLAGS_EN is defined.
interface bk_subtractor_pipe_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] DIFF;
   logic             borrow;
   logic             ovf;
   logic [TAG_W-1:0] out_tag;
`ifdef BK_SUB_FLAGS_EN
   logic             zero;
   logic             neg;
`endif

   // Subtractor side
   modport slave (
      input  in_valid, A, B, in_tag, out_ready,
      output in_ready, out_valid, DIFF, borrow, ovf, out_tag
`ifdef BK_SUB_FLAGS_EN
      , output zero, neg
`endif
   );

   // Producer/consumer side
   modport master (
      output in_valid, A, B, in_tag, out_ready,
      input  in_ready, out_valid, DIFF, borrow, ovf, out_tag
`ifdef BK_SUB_FLAGS_EN
      , input zero, neg
`endif
   );
endinterface

// File: rtl/bk_subtractor_pipe.sv
// Three-stage pipelined DIFF = A + ~B + 1 on a Brent-Kung prefix carry network, valid/ready on both sides.
// Optional zero/neg result flags are added when BK_SUB_FLAGS_EN is defined.
module bk_subtractor_pipe #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   bk_subtractor_pipe_if.slave bus
);
   localparam int unsigned LOG_W = $clog2(WIDTH);
   localparam int unsigned SPLIT = LOG_W / 2;
   localparam int unsigned MSB   = WIDTH - 1;

   if ((WIDTH < 8) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("bk_subtractor_pipe: WIDTH must be a power of 2 in 8..64");
   end
   if (TAG_W < 1) begin : g_bad_tag
      $error("bk_subtractor_pipe: TAG_W must be >= 1");
   end

   // Up-sweep levels lo..hi: node i (i+1 a multiple of 2^l) absorbs the group 2^(l-1) below it.
   function automatic logic [2*WIDTH-1:0] up_sweep(input logic [WIDTH-1:0] g_in,
                                                   input logic [WIDTH-1:0] p_in,
                                                   input int lo, input int hi);
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      int s;
      int h;
      g = g_in;
      p = p_in;
      for (int l = 1; l <= int'(LOG_W); l++) begin
         if ((l >= lo) && (l <= hi)) begin
            s = 1 << l;
            h = s >> 1;
            for (int i = s - 1; i < int'(WIDTH); i += s) begin
               g[LOG_W'(i)] = g[LOG_W'(i)] | (p[LOG_W'(i)] & g[LOG_W'(i - h)]);
               p[LOG_W'(i)] = p[LOG_W'(i)] & p[LOG_W'(i - h)];
            end
         end
      end
      return {g, p};
   endfunction

   // Down-sweep fills the remaining prefixes; only generates are needed from here on.
   function automatic logic [WIDTH-1:0] down_sweep(input logic [WIDTH-1:0] g_in,
                                                   input logic [WIDTH-1:0] p_in);
      logic [WIDTH-1:0] g;
      int s;
      int h;
      g = g_in;
      for (int l = int'(LOG_W) - 1; l >= 1; l--) begin
         s = 1 << l;
         h = s >> 1;
         for (int i = s + h - 1; i < int'(WIDTH); i += s) begin
            g[LOG_W'(i)] = g[LOG_W'(i)] | (p_in[LOG_W'(i)] & g[LOG_W'(i - h)]);
         end
      end
      return g;
   endfunction

   // Handshake: a stage loads when empty or when its contents move on this cycle
   logic w_rdy1;
   logic w_rdy2;
   logic w_rdy3;
   logic r1_v;
   logic r2_v;
   logic r3_v;

   assign w_rdy3       = ~r3_v | bus.out_ready;
   assign w_rdy2       = ~r2_v | w_rdy3;
   assign w_rdy1       = ~r1_v | w_rdy2;
   assign bus.in_ready = w_rdy1;

   // S1: generate/propagate of A + ~B, with the carry-in of 1 folded into bit 0
   logic [WIDTH-1:0] w_g0;
   logic [WIDTH-1:0] w_p0;
   logic [WIDTH-1:0] r1_g;
   logic [WIDTH-1:0] r1_p;
   logic             r1_a_msb;
   logic             r1_b_msb;
   logic [TAG_W-1:0] r1_tag;

   always_comb begin
      w_g0    = bus.A & ~bus.B;
      w_p0    = bus.A ^ ~bus.B;
      w_g0[0] = w_g0[0] | w_p0[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_v     <= 1'b0;
         r1_g     <= '0;
         r1_p     <= '0;
         r1_a_msb <= 1'b0;
         r1_b_msb <= 1'b0;
         r1_tag   <= '0;
      end else if (w_rdy1) begin
         r1_v <= bus.in_valid;
         if (bus.in_valid) begin
            r1_g     <= w_g0;
            r1_p     <= w_p0;
            r1_a_msb <= bus.A[MSB];
            r1_b_msb <= bus.B[MSB];
            r1_tag   <= bus.in_tag;
         end
      end
   end

   // S2: lower half of the up-sweep
   logic [2*WIDTH-1:0] w_up2;
   logic [WIDTH-1:0]   r2_g;
   logic [WIDTH-1:0]   r2_p;
   logic [WIDTH-1:0]   r2_hp;
   logic               r2_a_msb;
   logic               r2_b_msb;
   logic [TAG_W-1:0]   r2_tag;

   assign w_up2 = up_sweep(r1_g, r1_p, 1, int'(SPLIT));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r2_v     <= 1'b0;
         r2_g     <= '0;
         r2_p     <= '0;
         r2_hp    <= '0;
         r2_a_msb <= 1'b0;
         r2_b_msb <= 1'b0;
         r2_tag   <= '0;
      end else if (w_rdy2) begin
         r2_v <= r1_v;
         if (r1_v) begin
            r2_g     <= w_up2[2*WIDTH-1:WIDTH];
            r2_p     <= w_up2[WIDTH-1:0];
            r2_hp    <= r1_p;
            r2_a_msb <= r1_a_msb;
            r2_b_msb <= r1_b_msb;
            r2_tag   <= r1_tag;
         end
      end
   end

   // S3: finish the prefix tree, form carries, sum and flags
   logic [2*WIDTH-1:0] w_up3;
   logic [WIDTH-1:0]   w_pre;
   logic [WIDTH-1:0]   w_carry;
   logic [WIDTH-1:0]   w_diff;
   logic               w_borrow;
   logic               w_ovf;
   logic [WIDTH-1:0]   r3_diff;
   logic               r3_borrow;
   logic               r3_ovf;
   logic [TAG_W-1:0]   r3_tag;

   assign w_up3    = up_sweep(r2_g, r2_p, int'(SPLIT) + 1, int'(LOG_W));
   assign w_pre    = down_sweep(w_up3[2*WIDTH-1:WIDTH], w_up3[WIDTH-1:0]);
   assign w_carry  = {w_pre[WIDTH-2:0], 1'b1};
   assign w_diff   = r2_hp ^ w_carry;
   assign w_borrow = ~w_pre[MSB];
   assign w_ovf    = (r2_a_msb ^ r2_b_msb) & (w_diff[MSB] ^ r2_a_msb);

`ifdef BK_SUB_FLAGS_EN
   logic r3_zero;
   logic r3_neg;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r3_v      <= 1'b0;
         r3_diff   <= '0;
         r3_borrow <= 1'b0;
         r3_ovf    <= 1'b0;
         r3_tag    <= '0;
`ifdef BK_SUB_FLAGS_EN
         r3_zero   <= 1'b0;
         r3_neg    <= 1'b0;
`endif
      end else if (w_rdy3) begin
         r3_v <= r2_v;
         if (r2_v) begin
            r3_diff   <= w_diff;
            r3_borrow <= w_borrow;
            r3_ovf    <= w_ovf;
            r3_tag    <= r2_tag;
`ifdef BK_SUB_FLAGS_EN
            r3_zero   <= (w_diff == '0);
            r3_neg    <= w_diff[MSB];
`endif
         end
      end
   end

   assign bus.out_valid = r3_v;
   assign bus.DIFF      = r3_diff;
   assign bus.borrow    = r3_borrow;
   assign bus.ovf       = r3_ovf;
   assign bus.out_tag   = r3_tag;
`ifdef BK_SUB_FLAGS_EN
   assign bus.zero      = r3_zero;
   assign bus.neg       = r3_neg;
`endif
endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Bench for bk_subtractor_pipe: boundary vector table, backpressure and reset sequences, random stream vs model.
// Also checks zero/neg when built with BK_SUB_FLAGS_EN.
module tb_bk_subtractor_pipe;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned TAG_W = 4;
   localparam int          N_RAND = 10000;
   localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] SMIN  = 64'h8000_0000_0000_0000;
   localparam logic [63:0] SMAX  = 64'h7FFF_FFFF_FFFF_FFFF;

   typedef struct packed {
      logic [3:0]  tag;
      logic        ovf;
      logic        borrow;
      logic [63:0] diff;
   } res_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  tag;
      res_t        exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bk_subtractor_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();
   bk_subtractor_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int   n_run  = 0;
   int   n_fail = 0;
   res_t exp_q[$];
   vec_t vecs[12];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain modular / widened arithmetic
   function automatic res_t model(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
      res_t r;
      logic signed [64:0] sd;
      sd       = $signed({a[63], a}) - $signed({b[63], b});
      r.diff   = a - b;
      r.borrow = (a < b);
      r.ovf    = sd[64] ^ sd[63];
      r.tag    = tag;
      return r;
   endfunction

   function automatic logic [127:0] pack(input res_t r);
`ifdef BK_SUB_FLAGS_EN
      return 128'({r.diff == 64'd0, r.diff[63], r.tag, r.ovf, r.borrow, r.diff});
`else
      return 128'({r.tag, r.ovf, r.borrow, r.diff});
`endif
   endfunction

   function automatic logic [127:0] dut_out();
`ifdef BK_SUB_FLAGS_EN
      return 128'({bus.zero, bus.neg, bus.out_tag, bus.ovf, bus.borrow, bus.DIFF});
`else
      return 128'({bus.out_tag, bus.ovf, bus.borrow, bus.DIFF});
`endif
   endfunction

   function automatic vec_t mkvec(input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag,
                                  input logic [63:0] diff, input logic borrow, input logic ovf);
      vec_t v;
      v.a   = a;
      v.b   = b;
      v.tag = tag;
      v.exp = '{tag: tag, ovf: ovf, borrow: borrow, diff: diff};
      return v;
   endfunction

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(7))
         0:       return 64'd0;
         1:       return ONES;
         2:       return SMIN;
         3:       return SMAX;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // One isolated operation: checks the 3-cycle latency and the result
   task automatic apply_vec(input vec_t v, input string name);
      int lat;
      bus.A         = v.a;
      bus.B         = v.b;
      bus.in_tag    = v.tag;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      check({name, ".in_ready"}, 128'(bus.in_ready), 128'(1'b1));
      next_cycle();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         next_cycle();
         lat++;
      end
      check({name, ".latency"}, 128'(lat), 128'(3));
      check({name, ".result"}, dut_out(), pack(v.exp));
   endtask

   initial begin
      int k;
      int n_acc;
      int got;
      int sent;
      int cyc;
      int first_cyc;
      int last_cyc;
      int stale;
      logic prev_stall;
      res_t r;

      vecs[0]  = mkvec(64'd5, 64'd3, 4'd2, 64'd2, 1'b0, 1'b0);
      vecs[1]  = mkvec(64'd0, 64'd1, 4'd3, ONES, 1'b1, 1'b0);
      vecs[2]  = mkvec(64'h1234, 64'h1234, 4'd4, 64'd0, 1'b0, 1'b0);
      vecs[3]  = mkvec(SMIN, 64'd1, 4'd5, SMAX, 1'b0, 1'b1);
      vecs[4]  = mkvec(SMAX, ONES, 4'd6, SMIN, 1'b1, 1'b1);
      vecs[5]  = mkvec(64'd0, 64'd0, 4'd7, 64'd0, 1'b0, 1'b0);
      vecs[6]  = mkvec(ONES, ONES, 4'd8, 64'd0, 1'b0, 1'b0);
      vecs[7]  = mkvec(64'd0, SMIN, 4'd9, SMIN, 1'b1, 1'b1);
      vecs[8]  = mkvec(ONES, 64'd0, 4'hA, ONES, 1'b0, 1'b0);
      vecs[9]  = mkvec(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 4'hF,
                       64'h5555_5555_5555_5555, 1'b0, 1'b1);
      vecs[10] = mkvec(64'h100, 64'hFF, 4'h1, 64'd1, 1'b0, 1'b0);
      vecs[11] = mkvec(SMIN, SMAX, 4'hC, 64'd1, 1'b0, 1'b1);

      bus.in_valid  = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b0;
      repeat (3) next_cycle();
      check("reset.out_valid_held", 128'(bus.out_valid), 128'(1'b0));
      rst_n = 1'b1;
      next_cycle();
      check("reset.out_valid", 128'(bus.out_valid), 128'(1'b0));
      check("reset.in_ready", 128'(bus.in_ready), 128'(1'b1));
      check("reset.outputs", dut_out(), 128'(0));

      for (int i = 0; i < 12; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));
      next_cycle();

      // Backpressure: 8 ops offered with the consumer stalled
      bus.out_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 8; c++) begin
         bus.A        = 64'd100 + 64'(k);
         bus.B        = 64'(3 * k);
         bus.in_tag   = 4'(k);
         bus.in_valid = 1'b1;
         #1;
         if (bus.in_ready) begin
            exp_q.push_back(model(bus.A, bus.B, bus.in_tag));
            k++;
         end
         next_cycle();
      end
      check("bp.accepted", 128'(k), 128'(3));
      check("bp.in_ready_low", 128'(bus.in_ready), 128'(1'b0));
      check("bp.out_valid", 128'(bus.out_valid), 128'(1'b1));
      check("bp.head", dut_out(), pack(model(64'd100, 64'd0, 4'd0)));
      repeat (3) next_cycle();
      check("bp.held_valid", 128'(bus.out_valid), 128'(1'b1));
      check("bp.held", dut_out(), pack(model(64'd100, 64'd0, 4'd0)));

      bus.out_ready = 1'b1;
      got = 0;
      first_cyc = -1;
      last_cyc = -1;
      for (int c = 0; c < 30 && got < 8; c++) begin
         bus.in_valid = (k < 8);
         bus.A        = 64'd100 + 64'(k);
         bus.B        = 64'(3 * k);
         bus.in_tag   = 4'(k);
         #1;
         if (c == 0) check("bp.release_in_ready", 128'(bus.in_ready), 128'(1'b1));
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.A, bus.B, bus.in_tag));
            k++;
         end
         if (bus.out_valid) begin
            r = exp_q.pop_front();
            check($sformatf("bp.out%0d", got), dut_out(), pack(r));
            check($sformatf("bp.tag%0d", got), 128'(bus.out_tag), 128'(got));
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
            got++;
         end
         next_cycle();
      end
      bus.in_valid = 1'b0;
      check("bp.delivered", 128'(got), 128'(8));
      check("bp.first_cycle", 128'(first_cyc), 128'(0));
      check("bp.back_to_back", 128'(last_cyc - first_cyc), 128'(7));
      exp_q.delete();
      next_cycle();

      // Random stream with random valid/ready against the model
      sent = 0;
      got = 0;
      cyc = 0;
      prev_stall = 1'b0;
      while (got < N_RAND && cyc < 60000) begin
         bus.in_valid  = (sent < N_RAND) && ($urandom_range(3) != 0);
         bus.A         = rand_operand();
         bus.B         = rand_operand();
         bus.in_tag    = 4'($urandom);
         bus.out_ready = ($urandom_range(3) != 0);
         #1;
         if (prev_stall) begin
            check("rand.stall_valid", 128'(bus.out_valid), 128'(1'b1));
            if (exp_q.size() > 0) check("rand.stall_hold", dut_out(), pack(exp_q[0]));
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.A, bus.B, bus.in_tag));
            sent++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("rand.unexpected_output", 128'(1'b1), 128'(bus.out_valid == 1'b0));
            end else begin
               r = exp_q.pop_front();
               check("rand.result", dut_out(), pack(r));
            end
            got++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         next_cycle();
         cyc++;
      end
      bus.in_valid = 1'b0;
      check("rand.delivered", 128'(got), 128'(N_RAND));
      check("rand.queue_empty", 128'(exp_q.size()), 128'(0));

      // Reset with a full pipe: nothing in flight may surface afterwards
      bus.out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         bus.A        = 64'(c + 50);
         bus.B        = 64'd7;
         bus.in_tag   = 4'(c);
         bus.in_valid = 1'b1;
         next_cycle();
      end
      bus.in_valid = 1'b0;
      check("midrst.full", 128'(bus.out_valid), 128'(1'b1));
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.out_valid_drop", 128'(bus.out_valid), 128'(1'b0));
      check("midrst.outputs_clear", dut_out(), 128'(0));
      check("midrst.in_ready", 128'(bus.in_ready), 128'(1'b1));
      next_cycle();
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      stale = 0;
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         if (bus.out_valid) stale++;
      end
      check("midrst.no_stale", 128'(stale), 128'(0));
      apply_vec(vecs[0], "midrst.recover");
      next_cycle();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
